// File: rtl/interface_demux_pkg.sv
// Shared definitions for the egress demux: descriptor layout, port count and FSM states.
package interface_demux_pkg;

  localparam int NPORT   = 4;
  localparam int DESC_W  = 16;
  localparam int LEN_W   = 11;
  localparam int ERR_BIT = 15;
  localparam int MAP_MSB = 14;
  localparam int MAP_LSB = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_RD,
    ST_PTR_LAT,
    ST_WAIT_SPACE,
    ST_DATA,
    ST_DRAIN,
    ST_PTR_WR
  } state_t;

endpackage

// File: rtl/interface_demux_if.sv
// Bus bundle between the egress demux (master) and its shared/tx FIFOs (slave).
interface interface_demux_if
  import interface_demux_pkg::*;
#(
  parameter int CNT_W = 12
);
  logic              sfifo_rd;
  logic [7:0]        sfifo_dout;
  logic              sfifo_empty;
  logic              ptr_sfifo_rd;
  logic [DESC_W-1:0] ptr_sfifo_dout;
  logic              ptr_sfifo_empty;
  logic              tx_data_fifo_wr0, tx_data_fifo_wr1, tx_data_fifo_wr2, tx_data_fifo_wr3;
  logic [7:0]        tx_data_fifo_din;
  logic [CNT_W-1:0]  tx_data_fifo_cnt0, tx_data_fifo_cnt1, tx_data_fifo_cnt2, tx_data_fifo_cnt3;
  logic              tx_ptr_fifo_wr0, tx_ptr_fifo_wr1, tx_ptr_fifo_wr2, tx_ptr_fifo_wr3;
  logic [DESC_W-1:0] tx_ptr_fifo_din;
  logic              tx_ptr_fifo_full0, tx_ptr_fifo_full1, tx_ptr_fifo_full2, tx_ptr_fifo_full3;

  modport master (
    output sfifo_rd, ptr_sfifo_rd,
    input  sfifo_dout, sfifo_empty, ptr_sfifo_dout, ptr_sfifo_empty,
    output tx_data_fifo_wr0, tx_data_fifo_wr1, tx_data_fifo_wr2, tx_data_fifo_wr3, tx_data_fifo_din,
    input  tx_data_fifo_cnt0, tx_data_fifo_cnt1, tx_data_fifo_cnt2, tx_data_fifo_cnt3,
    output tx_ptr_fifo_wr0, tx_ptr_fifo_wr1, tx_ptr_fifo_wr2, tx_ptr_fifo_wr3, tx_ptr_fifo_din,
    input  tx_ptr_fifo_full0, tx_ptr_fifo_full1, tx_ptr_fifo_full2, tx_ptr_fifo_full3
  );

  modport slave (
    input  sfifo_rd, ptr_sfifo_rd,
    output sfifo_dout, sfifo_empty, ptr_sfifo_dout, ptr_sfifo_empty,
    input  tx_data_fifo_wr0, tx_data_fifo_wr1, tx_data_fifo_wr2, tx_data_fifo_wr3, tx_data_fifo_din,
    output tx_data_fifo_cnt0, tx_data_fifo_cnt1, tx_data_fifo_cnt2, tx_data_fifo_cnt3,
    input  tx_ptr_fifo_wr0, tx_ptr_fifo_wr1, tx_ptr_fifo_wr2, tx_ptr_fifo_wr3, tx_ptr_fifo_din,
    output tx_ptr_fifo_full0, tx_ptr_fifo_full1, tx_ptr_fifo_full2, tx_ptr_fifo_full3
  );

endinterface

// File: rtl/interface_demux_tx_space_check.sv
// Per-port admission check: an unmasked port is always ok; a masked one needs a free
// descriptor slot and room for the whole frame in its data FIFO (sum kept one bit wider).
module interface_demux_tx_space_check #(
  parameter int CNT_W      = 12,
  parameter int LEN_W      = 11,
  parameter int DATA_DEPTH = 4096
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             full,
  input  logic [LEN_W-1:0] len,
  input  logic             mask_bit,
  output logic             ok
);

  logic [CNT_W:0] need;

  assign need = {1'b0, cnt} + (CNT_W+1)'(len);
  assign ok   = !mask_bit || (!full && (need <= (CNT_W+1)'(DATA_DEPTH)));

endmodule

// File: rtl/interface_demux.sv
// Egress distributor: copies each shared-FIFO frame to all destination tx FIFOs once every one
// has room (never splits a frame). DEMUX_ERR_DROP_EN: frames flagged err are popped and discarded.
module interface_demux
  import interface_demux_pkg::*;
#(
  parameter int DATA_DEPTH = 4096,
  parameter int CNT_W      = 12,
  parameter int FRAME_MAX  = 1518
) (
  input logic               clk,
  input logic               rstn,
  interface_demux_if.master bus
);

`ifdef DEMUX_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  state_t            state;
  logic [NPORT-1:0]  mask;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  remaining;
  logic              drop;
  logic              rd_q;
  logic              ptr_rd;
  logic [NPORT-1:0]  ptr_wr;
  logic [DESC_W-1:0] ptr_din;

  logic [LEN_W-1:0]  desc_len;
  logic [NPORT-1:0]  desc_map;
  logic              desc_err;
  logic              data_rd;
  logic [NPORT-1:0]  data_wr;
  logic [NPORT-1:0]  full;
  logic [CNT_W-1:0]  cnt [NPORT];
  logic [NPORT-1:0]  ok;

  assign desc_len = bus.ptr_sfifo_dout[LEN_W-1:0];
  assign desc_map = bus.ptr_sfifo_dout[MAP_MSB:MAP_LSB];
  assign desc_err = bus.ptr_sfifo_dout[ERR_BIT];

  assign full   = {bus.tx_ptr_fifo_full3, bus.tx_ptr_fifo_full2,
                   bus.tx_ptr_fifo_full1, bus.tx_ptr_fifo_full0};
  assign cnt[0] = bus.tx_data_fifo_cnt0;
  assign cnt[1] = bus.tx_data_fifo_cnt1;
  assign cnt[2] = bus.tx_data_fifo_cnt2;
  assign cnt[3] = bus.tx_data_fifo_cnt3;

  for (genvar i = 0; i < NPORT; i++) begin : g_space
    interface_demux_tx_space_check #(
      .CNT_W      (CNT_W),
      .LEN_W      (LEN_W),
      .DATA_DEPTH (DATA_DEPTH)
    ) u_space_check (
      .cnt      (cnt[i]),
      .full     (full[i]),
      .len      (len),
      .mask_bit (mask[i]),
      .ok       (ok[i])
    );
  end

  // The byte read strobe must see this cycle's empty flag, otherwise a registered strobe could pop past empty.
  assign data_rd = (state == ST_DATA) && (remaining != '0) && !bus.sfifo_empty;
  assign data_wr = {NPORT{rd_q & ~drop}} & mask;

  assign bus.sfifo_rd         = data_rd;
  assign bus.ptr_sfifo_rd     = ptr_rd;
  assign bus.tx_data_fifo_din = rd_q ? bus.sfifo_dout : '0;
  assign bus.tx_data_fifo_wr0 = data_wr[0];
  assign bus.tx_data_fifo_wr1 = data_wr[1];
  assign bus.tx_data_fifo_wr2 = data_wr[2];
  assign bus.tx_data_fifo_wr3 = data_wr[3];
  assign bus.tx_ptr_fifo_din  = ptr_din;
  assign bus.tx_ptr_fifo_wr0  = ptr_wr[0];
  assign bus.tx_ptr_fifo_wr1  = ptr_wr[1];
  assign bus.tx_ptr_fifo_wr2  = ptr_wr[2];
  assign bus.tx_ptr_fifo_wr3  = ptr_wr[3];

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_IDLE;
      mask      <= '0;
      len       <= '0;
      remaining <= '0;
      drop      <= 1'b0;
      rd_q      <= 1'b0;
      ptr_rd    <= 1'b0;
      ptr_wr    <= '0;
      ptr_din   <= '0;
    end else begin
      ptr_rd <= 1'b0;
      ptr_wr <= '0;
      rd_q   <= data_rd;
      case (state)
        ST_IDLE: begin
          if (!bus.ptr_sfifo_empty) begin
            ptr_rd <= 1'b1;
            state  <= ST_PTR_RD;
          end
        end
        ST_PTR_RD: state <= ST_PTR_LAT;
        ST_PTR_LAT: begin
          len       <= desc_len;
          remaining <= desc_len;
          ptr_din   <= {{(DESC_W-LEN_W){1'b0}}, desc_len};
          drop      <= (desc_map == '0) || (int'(desc_len) > FRAME_MAX) || (desc_err && ERR_DROP);
          if (desc_len == '0) begin
            mask  <= '0;
            state <= ST_PTR_WR;
          end else begin
            mask  <= desc_map;
            state <= ST_WAIT_SPACE;
          end
        end
        ST_WAIT_SPACE: begin
          if (drop || (&ok)) state <= ST_DATA;
        end
        ST_DATA: begin
          if (data_rd) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          ptr_wr <= drop ? '0 : mask;
          state  <= ST_PTR_WR;
        end
        ST_PTR_WR: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interface_demux.sv
// Directed bench for interface_demux: models the shared FIFOs, logs every tx write per port,
// runs a vector table of frames plus backpressure, space, stall and mid-frame reset sequences.
module tb_interface_demux;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  interface_demux_if bus ();

  interface_demux dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Shared FIFO models
  logic [7:0]  dmem [8192];
  logic [15:0] pmem [64];
  int wp, rp, pwp, prp, underflow;
  logic hold_empty;

  assign bus.sfifo_empty     = (rp == wp) || hold_empty;
  assign bus.ptr_sfifo_empty = (prp == pwp);

  always @(posedge clk) begin
    if (rstn) begin
      rp                 <= wp;
      prp                <= pwp;
      bus.sfifo_dout     <= 8'h00;
      bus.ptr_sfifo_dout <= 16'h0000;
    end else begin
      if (bus.sfifo_rd) begin
        if (rp != wp) begin
          bus.sfifo_dout <= dmem[rp];
          rp             <= rp + 1;
        end else underflow <= underflow + 1;
      end
      if (bus.ptr_sfifo_rd) begin
        if (prp != pwp) begin
          bus.ptr_sfifo_dout <= pmem[prp];
          prp                <= prp + 1;
        end else underflow <= underflow + 1;
      end
    end
  end

  // Write monitor, sampled mid-cycle
  int cyc, rd_tot, lock_err;
  int dtot [4];
  int ptot [4];
  int last_d [4];
  int last_p [4];
  logic [15:0] pdin_last [4];
  logic [7:0]  dlog [4][8192];
  logic [3:0]  exp_wr;

  always @(negedge clk) begin
    logic [3:0] dw, pw;
    dw = {bus.tx_data_fifo_wr3, bus.tx_data_fifo_wr2, bus.tx_data_fifo_wr1, bus.tx_data_fifo_wr0};
    pw = {bus.tx_ptr_fifo_wr3, bus.tx_ptr_fifo_wr2, bus.tx_ptr_fifo_wr1, bus.tx_ptr_fifo_wr0};
    cyc = cyc + 1;
    if (bus.sfifo_rd) rd_tot = rd_tot + 1;
    if (dw != 4'b0000 && dw != exp_wr) lock_err = lock_err + 1;
    for (int i = 0; i < 4; i++) begin
      if (dw[i]) begin
        dlog[i][dtot[i]] = bus.tx_data_fifo_din;
        dtot[i]   = dtot[i] + 1;
        last_d[i] = cyc;
      end
      if (pw[i]) begin
        ptot[i]      = ptot[i] + 1;
        pdin_last[i] = bus.tx_ptr_fifo_din;
        last_p[i]    = cyc;
      end
    end
  end

  int n_cmp, n_bad;
  int s_d [4];
  int s_p [4];
  int s_rd, s_lock;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push_frame(input logic err, input logic [3:0] map, input int len,
                            input int base, input logic [3:0] expw);
    for (int i = 0; i < 4; i++) begin
      s_d[i] = dtot[i];
      s_p[i] = ptot[i];
    end
    s_rd   = rd_tot;
    s_lock = lock_err;
    exp_wr = expw;
    for (int k = 0; k < len; k++) begin
      dmem[wp] = 8'(base + k);
      wp++;
    end
    pmem[pwp] = {err, map, 11'(len)};
    pwp++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while ((rp != wp || prp != pwp) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " frame consumed"}, (rp == wp && prp == pwp) ? 1 : 0, 1);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] expw, input int len, input int base);
    for (int i = 0; i < 4; i++) begin
      int got, bad;
      got = dtot[i] - s_d[i];
      chk($sformatf("%s p%0d data count", tag, i), got, expw[i] ? len : 0);
      chk($sformatf("%s p%0d ptr count", tag, i), ptot[i] - s_p[i], expw[i] ? 1 : 0);
      if (expw[i]) begin
        bad = 0;
        for (int k = 0; k < got && k < len; k++)
          if (dlog[i][s_d[i] + k] != 8'(base + k)) bad++;
        chk($sformatf("%s p%0d byte errors", tag, i), bad, 0);
        chk($sformatf("%s p%0d ptr din", tag, i), int'(pdin_last[i]), len);
        chk($sformatf("%s p%0d data before ptr", tag, i), (last_d[i] < last_p[i]) ? 1 : 0, 1);
      end
    end
    chk({tag, " rd strobes"}, rd_tot - s_rd, len);
    chk({tag, " lockstep"}, lock_err - s_lock, 0);
  endtask

  typedef struct {
    logic       err;
    logic [3:0] map;
    int         len;
    logic [3:0] expw;
  } vec_t;

  vec_t vt [9];

  initial begin
    int n;
    int k;
    vt[0] = '{1'b0, 4'b0100,   64, 4'b0100};  // unicast to port 2
    vt[1] = '{1'b0, 4'b1011,   60, 4'b1011};  // multicast 0,1,3
    vt[2] = '{1'b0, 4'b0000,  100, 4'b0000};  // empty portmap: drop
    vt[3] = '{1'b0, 4'b0001, 1600, 4'b0000};  // oversize: drop
`ifdef DEMUX_ERR_DROP_EN
    vt[4] = '{1'b1, 4'b0010,   30, 4'b0000};
`else
    vt[4] = '{1'b1, 4'b0010,   30, 4'b0010};
`endif
    vt[5] = '{1'b0, 4'b1000, 1518, 4'b1000};  // longest legal frame
    vt[6] = '{1'b0, 4'b1000, 1519, 4'b0000};  // one byte too long
    vt[7] = '{1'b0, 4'b0001,    0, 4'b0000};  // zero length: no writes at all
    vt[8] = '{1'b0, 4'b1111,    1, 4'b1111};  // single byte broadcast

    rstn = 1'b1;
    hold_empty = 1'b0;
    wp = 0; pwp = 0; underflow = 0;
    exp_wr = 4'b0000;
    bus.tx_data_fifo_cnt0 = '0; bus.tx_data_fifo_cnt1 = '0;
    bus.tx_data_fifo_cnt2 = '0; bus.tx_data_fifo_cnt3 = '0;
    bus.tx_ptr_fifo_full0 = 1'b0; bus.tx_ptr_fifo_full1 = 1'b0;
    bus.tx_ptr_fifo_full2 = 1'b0; bus.tx_ptr_fifo_full3 = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset sfifo_rd", int'(bus.sfifo_rd), 0);
    chk("reset ptr_sfifo_rd", int'(bus.ptr_sfifo_rd), 0);
    chk("reset data wr", int'({bus.tx_data_fifo_wr3, bus.tx_data_fifo_wr2,
                               bus.tx_data_fifo_wr1, bus.tx_data_fifo_wr0}), 0);
    chk("reset ptr wr", int'({bus.tx_ptr_fifo_wr3, bus.tx_ptr_fifo_wr2,
                              bus.tx_ptr_fifo_wr1, bus.tx_ptr_fifo_wr0}), 0);
    chk("reset data din", int'(bus.tx_data_fifo_din), 0);
    chk("reset ptr din", int'(bus.tx_ptr_fifo_din), 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle no ptr read", int'(bus.ptr_sfifo_rd), 0);

    for (int v = 0; v < 9; v++) begin
      push_frame(vt[v].err, vt[v].map, vt[v].len, v * 37, vt[v].expw);
      wait_done($sformatf("vec%0d", v), vt[v].len + 50);
      check_frame($sformatf("vec%0d", v), vt[v].expw, vt[v].len, v * 37);
    end

    // Descriptor FIFO full on the only destination blocks the frame
    bus.tx_ptr_fifo_full1 = 1'b1;
    push_frame(1'b0, 4'b0010, 20, 80, 4'b0010);
    repeat (20) @(posedge clk); #1;
    chk("bp no read while full", rd_tot - s_rd, 0);
    bus.tx_ptr_fifo_full1 = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("bp start within 2 cycles", (rd_tot - s_rd > 0) ? 1 : 0, 1);
    wait_done("bp", 100);
    check_frame("bp", 4'b0010, 20, 80);

    // Data FIFO space: 4040+64 and 4033+64 overflow, 4032+64 fits exactly
    bus.tx_data_fifo_cnt0 = 12'd4040;
    push_frame(1'b0, 4'b0001, 64, 120, 4'b0001);
    repeat (15) @(posedge clk); #1;
    chk("space 4040 waits", rd_tot - s_rd, 0);
    bus.tx_data_fifo_cnt0 = 12'd4033;
    repeat (10) @(posedge clk); #1;
    chk("space 4033 waits", rd_tot - s_rd, 0);
    bus.tx_data_fifo_cnt0 = 12'd4032;
    repeat (2) @(posedge clk); #1;
    chk("space 4032 proceeds", (rd_tot - s_rd > 0) ? 1 : 0, 1);
    wait_done("space", 150);
    bus.tx_data_fifo_cnt0 = '0;
    check_frame("space", 4'b0001, 64, 120);

    // Shared data FIFO runs dry mid-frame
    push_frame(1'b0, 4'b0100, 40, 160, 4'b0100);
    k = 0;
    while (rd_tot - s_rd < 10 && k < 100) begin @(posedge clk); #1; k++; end
    chk("stall reached mid-frame", (rd_tot - s_rd >= 10) ? 1 : 0, 1);
    hold_empty = 1'b1;
    n = rd_tot;
    repeat (5) @(posedge clk); #1;
    chk("stall no read while empty", rd_tot - n, 0);
    hold_empty = 1'b0;
    wait_done("stall", 100);
    check_frame("stall", 4'b0100, 40, 160);

    // Reset in the middle of a frame, then a clean frame afterwards
    push_frame(1'b0, 4'b0001, 50, 200, 4'b0001);
    k = 0;
    while (rd_tot - s_rd < 10 && k < 100) begin @(posedge clk); #1; k++; end
    chk("rst reached mid-frame", (rd_tot - s_rd >= 10) ? 1 : 0, 1);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst strobes cleared", int'({bus.sfifo_rd, bus.ptr_sfifo_rd,
                                     bus.tx_data_fifo_wr3, bus.tx_data_fifo_wr2,
                                     bus.tx_data_fifo_wr1, bus.tx_data_fifo_wr0,
                                     bus.tx_ptr_fifo_wr3, bus.tx_ptr_fifo_wr2,
                                     bus.tx_ptr_fifo_wr1, bus.tx_ptr_fifo_wr0}), 0);
    n = dtot[0] + ptot[0];
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("rst no writes after abandon", dtot[0] + ptot[0] - n, 0);
    push_frame(1'b0, 4'b0001, 16, 240, 4'b0001);
    wait_done("post-rst", 80);
    check_frame("post-rst", 4'b0001, 16, 240);

    chk("no read of empty FIFO", underflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
